// File: rtl/avalon_panel_io_if.sv
// Avalon-MM slave bus bundle for avalon_panel_io: word address, strobes and 32-bit data.
// The readdata return path is registered inside the slave with a fixed read latency of 1.
interface avalon_panel_io_if;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/avalon_panel_io.sv
// Panel I/O Avalon-MM slave: synchronised switches, debounced keys with press capture and irq, LEDs, HEX.
// Define AVALON_PANEL_HEX_DECODE_EN to store 5-bit {blank, nibble} HEX codes and decode them to segments.
module avalon_panel_io #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4,
  parameter int N_LED           = 10,
  parameter int N_HEX           = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  avalon_panel_io_if.slave   avs,
  output logic               irq,
  input  logic [N_SW-1:0]    switches_export,
  input  logic [N_KEY-1:0]   pushbuttons_export,
  output logic [N_LED-1:0]   rled_export,
  output logic [7*N_HEX-1:0] hex_export
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

`ifdef AVALON_PANEL_HEX_DECODE_EN
  localparam int HW = 5;
  localparam logic [HW-1:0] HEX_RST = 5'h10;
`else
  localparam int HW = 7;
  localparam logic [HW-1:0] HEX_RST = 7'h7F;
`endif

  logic [N_SW-1:0]  sw_meta, sw_sync;
  logic [N_KEY-1:0] key_meta, key_sync;
  logic [N_KEY-1:0] stable, stable_next, press;
  logic [CW-1:0]    cnt      [N_KEY];
  logic [CW-1:0]    cnt_next [N_KEY];
  logic [N_KEY-1:0] edge_reg, mask_reg;
  logic [N_LED-1:0] led_reg;
  logic [HW-1:0]    hex_reg  [N_HEX];
  logic [31:0]      rd_mux;
  logic             wr_edge, wr_mask, wr_led;
  logic             unused_wdata;

  assign unused_wdata = ^avs.avs_writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      sw_meta  <= switches_export;
      sw_sync  <= sw_meta;
      key_meta <= pushbuttons_export;
      key_sync <= key_meta;
    end
  end

  // A key is accepted only after it has differed from the accepted level for DEBOUNCE_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      cnt_next[i]    = '0;
      stable_next[i] = stable[i];
      if (key_sync[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_next[i] = key_sync[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '1;
      for (int i = 0; i < N_KEY; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_next;
      for (int i = 0; i < N_KEY; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign wr_edge = avs.avs_write && (avs.avs_address == 4'd2);
  assign wr_mask = avs.avs_write && (avs.avs_address == 4'd3);
  assign wr_led  = avs.avs_write && (avs.avs_address == 4'd4);

  // A press landing in the same cycle as a W1C clear must survive, so the set is OR-ed in last.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_reg <= '0;
      mask_reg <= '0;
      led_reg  <= '0;
      irq      <= 1'b0;
      for (int i = 0; i < N_HEX; i++) hex_reg[i] <= HEX_RST;
    end else begin
      edge_reg <= (edge_reg & ~(wr_edge ? avs.avs_writedata[N_KEY-1:0] : '0)) | press;
      irq      <= |(edge_reg & mask_reg);
      if (wr_mask) mask_reg <= avs.avs_writedata[N_KEY-1:0];
      if (wr_led)  led_reg  <= avs.avs_writedata[N_LED-1:0];
      for (int i = 0; i < N_HEX; i++) begin
        if (avs.avs_write && (avs.avs_address == 4'(8 + i))) begin
          hex_reg[i] <= avs.avs_writedata[HW-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      4'd0: rd_mux[N_SW-1:0]  = sw_sync;
      4'd1: rd_mux[N_KEY-1:0] = ~stable;
      4'd2: rd_mux[N_KEY-1:0] = edge_reg;
      4'd3: rd_mux[N_KEY-1:0] = mask_reg;
      4'd4: rd_mux[N_LED-1:0] = led_reg;
      default: begin
        for (int i = 0; i < N_HEX; i++) begin
          if (avs.avs_address == 4'(8 + i)) rd_mux[HW-1:0] = hex_reg[i];
        end
      end
    endcase
  end

  // Read data is sampled from pre-write register values, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs.avs_readdata <= '0;
    end else if (avs.avs_read) begin
      avs.avs_readdata <= rd_mux;
    end
  end

  assign rled_export = led_reg;

`ifdef AVALON_PANEL_HEX_DECODE_EN
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction
`endif

  for (genvar g = 0; g < N_HEX; g++) begin : g_hex
`ifdef AVALON_PANEL_HEX_DECODE_EN
    assign hex_export[7*g +: 7] = hex_reg[g][4] ? 7'h7F : seg_decode(hex_reg[g][3:0]);
`else
    assign hex_export[7*g +: 7] = hex_reg[g];
`endif
  end

endmodule

// File: doc/avalon_panel_io.md
Name: avalon_panel_io

Overview:
- Parametrised Avalon-MM slave that replaces the separate switch, pushbutton, LED and HEX PIOs in the lab Qsys system with one block.
- Sits on the HPS lightweight bridge and exports panel pins to the top level.
- Adds features the stock PIOs lack: input synchronisation, per-key debounce, press edge capture with write-1-to-clear, and a masked interrupt.
- Has a configurable number of switches, keys, LEDs and HEX digits.

Parameters:
N_SW, 10, switch count (1..32)
N_KEY, 4, pushbutton count (1..32)
N_LED, 10, LED count (1..32)
N_HEX, 6, seven-segment digit count (1..8)
DEBOUNCE_CYCLES, 500000, cycles a key input must stay stable before it is accepted (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
avs_address  in  4  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
irq  out  1  interrupt, level, active-high
switches_export  in  N_SW  raw switch inputs
pushbuttons_export  in  N_KEY  raw keys, active-low (pressed = 0)
rled_export  out  N_LED  LED drive, active-high
hex_export  out  7*N_HEX  segments, digit i at [7i+6:7i], active-low

Behaviour:
- One clock. Reset is synchronous and active-high.
- All inputs pass through a 2-flop synchroniser. Reset value: switch flops 0, key flops all 1.
- Debounce, per key: raw = synchronised key, stable = accepted key.
  - If raw != stable, the key's counter increments.
  - If raw == stable, the counter clears to 0.
  - When the counter = DEBOUNCE_CYCLES-1 and raw != stable, stable <= raw and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - stable resets to all 1.
- Edge capture: edge[i] sets on the cycle stable[i] goes 1->0 (press). Release is ignored.
- Register map (word address; unused upper bits read 0):
  - 0 SW: RO, synchronised switches.
  - 1 KEY: RO, ~stable, so 1 = pressed.
  - 2 EDGE: R/W1C. Writing 1 to a bit clears it.
  - 3 MASK: R/W, interrupt enable per key.
  - 4 LED: R/W, drives rled_export.
  - 5..7: reserved, read 0, writes ignored.
  - 8+i, i<N_HEX: HEX digit i, R/W, bits [6:0] drive segments. Writes to i>=N_HEX are ignored and reads return 0.
- Reads: avs_readdata is updated on the clock after avs_read is sampled (fixed latency 1) and holds its value until the next read. No waitrequest.
- Writes take effect on the clock edge where avs_write is sampled. Writes to RO registers are ignored.
- Simultaneous read and write to one address: the read returns the old value.
- Edge set and W1C clear of the same bit in the same cycle: set wins (bit stays 1).
- irq = |(EDGE & MASK), registered, so it asserts 1 cycle after the edge or mask change.
- Reset values: avs_readdata 0, irq 0, EDGE 0, MASK 0, LED 0, every HEX register 7'h7F (all segments off).
- Reset asserted mid-debounce clears all counters. No spurious edge is generated after reset release.

Optional Feature:
- Macro: AVALON_PANEL_HEX_DECODE_EN.
- When defined:
  - Each HEX register is 5 bits: bit4 = blank, bits[3:0] = hex value.
  - A combinational decoder drives the active-low segment pattern for 0..F. Blank=1 gives 7'h7F.
  - Reset value is 5'h10 (blank).
  - Reads return only the 5 stored bits.
- When undefined: raw 7-bit segment registers as described above.

Test Plan:
- Reset, then read addresses 0,1,2,3,4,8 -> readdata 0,0,0,0,0,0x7F (HEX raw mode); rled_export=0; hex_export all 1s; irq=0.
- DEBOUNCE_CYCLES=4. Drive pushbuttons_export[0]=0 with 2-cycle glitches -> KEY stays 0. Hold 0 for 6 cycles -> KEY=0x1 and EDGE=0x1. Release -> EDGE remains 0x1.
- MASK=0x1, then a key0 press -> irq=1 one cycle after EDGE sets. Write EDGE=0x1 -> EDGE=0 and irq=0 next cycle. Press key1 with MASK=0x1 -> EDGE=0x2, irq stays 0.
- Key0 edge arrives in the same cycle as a W1C write of 0x1 to EDGE -> EDGE[0]=1 afterwards.
- Write LED=0x3FF and HEX digit 5 (addr 13)=0x40 -> rled_export=0x3FF, hex_export[41:35]=0x40. Write addr 14 (N_HEX=6) -> no output change, read returns 0.
- With AVALON_PANEL_HEX_DECODE_EN: write addr 8 = 0x0A -> hex_export[6:0]=7'h08. Write 0x10 -> 7'h7F. Switches=0x2A5 -> SW read 0x2A5 from the third cycle on.
